mudv_unit: RTL and testbench
============================

// Module: mudv_unit
// PURPOSE
// - Multiply/divide execution unit with HI/LO registers. Sits in the EX stage beside the ALU.
// - Consumes the MUDV control group from the main decoder: start, op, wen and ressrc.
// - Runs one multicycle operation at a time and reports busy, which the hazard unit uses to stall.
// PARAMETERS
// - MULT_LAT  5   cycles from an accepted mult/multu/madd* to the HI/LO update (>=1)
// - DIV_LAT  10   cycles from an accepted div/divu to the HI/LO update (>=1)
// - CNT_W     4   busy counter width; must hold max(MULT_LAT, DIV_LAT)
// PORTS
// - clk     in   1   clock; all state updates on the rising edge
// - rst_n   in   1   asynchronous, active-low reset
// - start   in   1   request a MUDV operation this cycle
// - op      in   3   000 mult, 001 multu, 010 div, 011 divu; 100 madd, 101 maddu with MUDV_MADD_EN
// - wen     in   2   10 = write HI from wdata (mthi); 01 = write LO (mtlo); 00/11 = none
// - ressrc  in   2   10 = res from HI; 01 = res from LO; other = res 0
// - a       in   32  operand rs (dividend, multiplicand)
// - b       in   32  operand rt (divisor, multiplier)
// - wdata   in   32  mthi/mtlo data (rs)
// - busy    out  1   operation in flight
// - hi      out  32  HI register
// - lo      out  32  LO register
// - res     out  32  combinational read mux selected by ressrc
// BEHAVIOUR
// - Reset (async, rst_n=0): hi=0, lo=0, cnt=0, busy=0, operand/op latches=0. Effective immediately.
//   Reset mid-operation aborts the operation with no HI/LO write.
// - busy = (cnt != 0). State: IDLE (cnt==0), RUN (cnt!=0).
// - Accept: start && !busy at an edge latches a, b, op and loads cnt with MULT_LAT (op[1]==0)
//   or DIV_LAT (op[1]==1). Any unsupported op (op[2]==1 without the feature, or 11x) is dropped:
//   cnt stays 0 and HI/LO are unchanged.
// - RUN: cnt decrements each edge. At the edge where cnt==1, HI/LO take the result and cnt becomes 0.
//   busy is therefore high for exactly LAT cycles after the accept edge.
// - start while busy: ignored. No restart, no queue. The hazard unit must stall.
// - mult: signed 64-bit product, {hi,lo} = $signed(a)*$signed(b). multu: unsigned product.
// - div:  lo = signed quotient truncated toward 0; hi = remainder, which takes the sign of the dividend.
//   divu: unsigned quotient and remainder.
// - div/divu with b==0: the operation runs full DIV_LAT, then HI/LO are left unchanged.
// - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
// - wen when idle and not accepting: the selected register takes wdata at the edge.
//   wen while busy: ignored.
// - start and wen in the same cycle: start has priority and wen is dropped.
// - HI/LO reads during RUN return the old values.
// - res is combinational from hi/lo/ressrc and has no latency. ressrc=11 gives res=0.
// CONFIGURATION
// - MUDV_MADD_EN defined:
//   - op 100 (madd): {hi,lo} += signed product.
//   - op 101 (maddu): {hi,lo} += unsigned product.
//   - Both use MULT_LAT. The addition is 64-bit and wraps modulo 2^64.
//   - The accumulate base is the HI/LO value at the completion edge.
// - MUDV_MADD_EN undefined: op[2]==1 is an unsupported op. The accumulate adder is not built.
// TESTING
// - mult a=0xFFFFFFFD b=5, start 1 cycle -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFF1, busy=0
// - divu a=17 b=5 -> busy 10 cycles, then lo=3 hi=2; div a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF
// - mult in flight, start divu at cycle 2 -> ignored; only the mult result lands at cycle 5; busy drops once
// - idle wen=10 wdata=0x1234 -> hi=0x1234; ressrc=10 -> res=0x1234; wen=01 during busy -> lo unchanged
// - div b=0 with hi=0xA lo=0xB -> busy 10 cycles, hi=0xA lo=0xB; rst_n=0 at cycle 3 of a mult -> hi=lo=0, busy=0 at once
// - MUDV_MADD_EN: hi:lo=0:0xFFFFFFFF, maddu a=1 b=1 -> hi=1 lo=0; undefined: same stimulus -> busy never rises

Source files
------------

// File: rtl/mudv_if.sv
// MUDV control/data bundle between the decoder/EX datapath (master) and the
// multiply/divide unit (slave).
interface mudv_if;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  wen;
  logic [1:0]  ressrc;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res;

  modport master (
    output start, op, wen, ressrc, a, b, wdata,
    input  busy, hi, lo, res
  );

  modport slave (
    input  start, op, wen, ressrc, a, b, wdata,
    output busy, hi, lo, res
  );
endinterface

// File: rtl/mudv_unit.sv
// Multiply/divide unit with HI/LO registers; one multicycle op at a time.
// Optional MUDV_MADD_EN adds madd/maddu (64-bit accumulate into HI:LO).
module mudv_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  mudv_if.slave mu
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     a_q, b_q, hi_q, lo_q;
  logic [2:0]      op_q;
  logic            op_ok, accept;

  always_comb begin
    op_ok = 1'b0;
    case (mu.op)
      3'b000, 3'b001, 3'b010, 3'b011: op_ok = 1'b1;
`ifdef MUDV_MADD_EN
      3'b100, 3'b101:                 op_ok = 1'b1;
`endif
      default:                        op_ok = 1'b0;
    endcase
  end

  assign accept = mu.start && (state == IDLE) && op_ok;

  // Both products as low 64 bits of a 64x64 multiply; sign-extension gives the signed one.
  logic [63:0] sprod, uprod;
  assign sprod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign uprod = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  logic [31:0] a_mag, b_mag, uq, ur, sq, sr, dq, dr;
  assign a_mag = a_q[31] ? -a_q : a_q;
  assign b_mag = b_q[31] ? -b_q : b_q;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign sq    = (a_q[31] ^ b_q[31]) ? -uq : uq;
  assign sr    = a_q[31] ? -ur : ur;
  assign dq    = a_q / b_q;
  assign dr    = a_q % b_q;

`ifdef MUDV_MADD_EN
  logic [63:0] madd_s, madd_u;
  assign madd_s = {hi_q, lo_q} + sprod;
  assign madd_u = {hi_q, lo_q} + uprod;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= mu.a;
            b_q   <= mu.b;
            op_q  <= mu.op;
            cnt   <= mu.op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state <= RUN;
          end else begin
            case (mu.wen)
              2'b10:   hi_q <= mu.wdata;
              2'b01:   lo_q <= mu.wdata;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            case (op_q)
              3'b000: {hi_q, lo_q} <= sprod;
              3'b001: {hi_q, lo_q} <= uprod;
              3'b010: if (b_q != '0) begin
                lo_q <= sq;
                hi_q <= sr;
              end
              3'b011: if (b_q != '0) begin
                lo_q <= dq;
                hi_q <= dr;
              end
`ifdef MUDV_MADD_EN
              3'b100: {hi_q, lo_q} <= madd_s;
              3'b101: {hi_q, lo_q} <= madd_u;
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mu.busy = (state == RUN);
  assign mu.hi   = hi_q;
  assign mu.lo   = lo_q;

  always_comb begin
    case (mu.ressrc)
      2'b10:   mu.res = hi_q;
      2'b01:   mu.res = lo_q;
      default: mu.res = '0;
    endcase
  end

endmodule

// File: tb/tb_mudv_unit.sv
// Directed bench for mudv_unit with an expected-result queue popped at each completion.
// Honours MUDV_MADD_EN the same way as the design.
module tb_mudv_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];

  mudv_if mu();

  mudv_unit #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mu    (mu.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    mu.wen = sel; mu.wdata = d;
    @(negedge clk);
    mu.wen = 2'b00; mu.wdata = '0;
  endtask

  // mode: 0 plain, 1 start divu mid-run, 2 wen=01 mid-run, 3 wen=10 with start
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int lat, input logic [63:0] prev, input int mode);
    int n;
    logic [63:0] e;
    @(negedge clk);
    mu.start = 1'b1; mu.op = o; mu.a = x; mu.b = y;
    if (mode == 3) begin mu.wen = 2'b10; mu.wdata = 32'h5555; end
    @(negedge clk);
    mu.start = 1'b0; mu.a = '0; mu.b = '0; mu.wen = 2'b00; mu.wdata = '0;
    n = 0;
    while (mu.busy && n < 60) begin
      n++;
      mu.start = 1'b0; mu.wen = 2'b00;
      if (n == 2 && mode == 1) begin
        mu.start = 1'b1; mu.op = 3'b011; mu.a = 100; mu.b = 7;
      end
      if (n == 2 && mode == 2) begin mu.wen = 2'b01; mu.wdata = 32'hDEAD; end
      if (n == 4) chk({tag, "_old"}, {mu.hi, mu.lo}, prev);
      @(negedge clk);
    end
    mu.start = 1'b0; mu.wen = 2'b00;
    chk({tag, "_busy"}, 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hilo"}, {mu.hi, mu.lo}, e);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    mu.start = 1'b0; mu.op = '0; mu.wen = '0; mu.ressrc = '0;
    mu.a = '0; mu.b = '0; mu.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(mu.busy), 64'd0);
    chk("rst_hilo", {mu.hi, mu.lo}, 64'd0);
    mu.ressrc = 2'b10;
    #1 chk("rst_res", 64'(mu.res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    run("mult", 3'b000, 32'hFFFFFFFD, 32'd5, 5, 64'd0, 0);
    sb.push_back({32'd2, 32'd3});
    run("divu", 3'b011, 32'd17, 32'd5, 10, {32'hFFFFFFFF, 32'hFFFFFFF1}, 0);
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 10, {32'd2, 32'd3}, 0);
    sb.push_back({32'h0, 32'h80000000});
    run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
    sb.push_back(64'hFFFFFFFE_00000001);
    run("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, {32'h0, 32'h80000000}, 0);

    sb.push_back({32'd0, 32'd12});
    run("intrude", 3'b000, 32'd3, 32'd4, 5, 64'hFFFFFFFE_00000001, 1);
    n = 0;
    repeat (15) begin
      if (mu.busy) n++;
      @(negedge clk);
    end
    chk("intrude_nobusy", 64'(n), 64'd0);
    chk("intrude_after", {mu.hi, mu.lo}, {32'd0, 32'd12});

    wr(2'b10, 32'h1234);
    chk("wen_hi", 64'(mu.hi), 64'h1234);
    mu.ressrc = 2'b10;
    #1 chk("res_hi", 64'(mu.res), 64'h1234);

    wr(2'b10, 32'hA);
    wr(2'b01, 32'hB);
    sb.push_back({32'hA, 32'hB});
    run("div0", 3'b010, 32'd5, 32'd0, 10, {32'hA, 32'hB}, 2);
    mu.ressrc = 2'b01;
    #1 chk("res_lo", 64'(mu.res), 64'hB);
    mu.ressrc = 2'b11;
    #1 chk("res_11", 64'(mu.res), 64'd0);
    mu.ressrc = 2'b00;
    #1 chk("res_00", 64'(mu.res), 64'd0);

    sb.push_back({32'd0, 32'd6});
    run("start_wen", 3'b000, 32'd2, 32'd3, 5, {32'hA, 32'hB}, 3);
    sb.push_back({32'd0, 32'd6});
    run("bad110", 3'b110, 32'd1, 32'd1, 0, {32'd0, 32'd6}, 0);
    sb.push_back({32'd0, 32'd6});
    run("bad111", 3'b111, 32'd1, 32'd1, 0, {32'd0, 32'd6}, 0);

    wr(2'b10, 32'h0);
    wr(2'b01, 32'hFFFFFFFF);
`ifdef MUDV_MADD_EN
    sb.push_back({32'd1, 32'd0});
    run("maddu", 3'b101, 32'd1, 32'd1, 5, {32'd0, 32'hFFFFFFFF}, 0);
    sb.push_back({32'd0, 32'hFFFFFFFF});
    run("madd", 3'b100, 32'hFFFFFFFF, 32'd1, 5, {32'd1, 32'd0}, 0);
`else
    sb.push_back({32'd0, 32'hFFFFFFFF});
    run("maddu", 3'b101, 32'd1, 32'd1, 0, {32'd0, 32'hFFFFFFFF}, 0);
    sb.push_back({32'd0, 32'hFFFFFFFF});
    run("madd", 3'b100, 32'hFFFFFFFF, 32'd1, 0, {32'd0, 32'hFFFFFFFF}, 0);
`endif

    wr(2'b10, 32'h77);
    @(negedge clk);
    mu.start = 1'b1; mu.op = 3'b000; mu.a = 32'd3; mu.b = 32'd3;
    @(negedge clk);
    mu.start = 1'b0;
    chk("rstmid_busy_pre", 64'(mu.busy), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(mu.busy), 64'd0);
    chk("rstmid_hilo", {mu.hi, mu.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstmid_after", {mu.busy, mu.hi, mu.lo}, 65'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
